cart_bus_seq: RTL and testbench

Sequencer that turns single-word host requests into timed cartridge-bus cycles for an MBC-equipped cartridge. It drives address, data, the read and write strobes and RAM chip select, and generates the cartridge reset. It keeps a shadow copy of the MBC1 bank and mode registers, so the rest of the system can see the current mapping without reading the cartridge. It sits between the simulated CPU/DMA side and the cartridge model.

---
 rtl/cart_pkg.sv | 28 ++
 rtl/mbc1_shadow.sv | 34 +++
 rtl/cart_bus_seq.sv | 132 +++++++++++++
 tb/tb_cart_bus_seq.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cart_pkg.sv
// Shared types and constants for the cartridge bus sequencer and its MBC1 shadow.
// Holds the bus state encoding, the external-RAM window and the MBC1 register decode values.
package cart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    ACK
  } bus_state_t;

  localparam logic [15:0] RAM_LO = 16'hA000;
  localparam logic [15:0] RAM_HI = 16'hFDFF;

  // MBC1 register select, taken from addr[14:13] of a write below 8000
  localparam logic [1:0] SEL_RAM_ENA  = 2'b00;
  localparam logic [1:0] SEL_ROM_BANK = 2'b01;
  localparam logic [1:0] SEL_RAM_BANK = 2'b10;
  localparam logic [1:0] SEL_MODE     = 2'b11;

  localparam logic [3:0] RAM_ENA_MAGIC = 4'hA;

  function automatic logic in_ram_window(input logic [15:0] a);
    return (a >= RAM_LO) && (a <= RAM_HI);
  endfunction

endpackage

// File: rtl/mbc1_shadow.sv
// Shadow copy of the four MBC1 control registers, updated by writes into 0000-7FFF.
// Only the address bits and data bits the MBC1 actually decodes are brought in.
module mbc1_shadow
  import cart_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [2:0] addr_hi,
  input  logic [4:0] data,
  output logic       ram_ena,
  output logic [4:0] rom_bank,
  output logic [1:0] ram_bank,
  output logic       mode
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_ena  <= 1'b0;
      rom_bank <= 5'd0;
      ram_bank <= 2'd0;
      mode     <= 1'b0;
    end else if (wr_en && !addr_hi[2]) begin
      case (addr_hi[1:0])
        SEL_RAM_ENA:  ram_ena  <= (data[3:0] == RAM_ENA_MAGIC);
        SEL_ROM_BANK: rom_bank <= data;
        SEL_RAM_BANK: ram_bank <= data[1:0];
        SEL_MODE:     mode     <= data[0];
        default:      ;
      endcase
    end
  end

endmodule

// File: rtl/cart_bus_seq.sv
// Turns single-word host requests into timed cartridge bus cycles (setup, strobe, hold, ack)
// and generates the cartridge reset; all bus pins come straight from flops.
module cart_bus_seq
  import cart_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 3,
  parameter int unsigned HOLD_CYC   = 1,
  parameter int unsigned RST_CYC    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic        ack,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        cart_nrst,
  output logic [15:0] cart_a,
  output logic [7:0]  cart_d_out,
  output logic        cart_d_oe,
  input  logic [7:0]  cart_d_in,
  output logic        cart_nrd,
  output logic        cart_nwr,
  output logic        cart_ncs,
  output logic        sh_ram_ena,
  output logic [4:0]  sh_rom_bank,
  output logic [1:0]  sh_ram_bank,
  output logic        sh_mode
);

  localparam int CW = 8;

  bus_state_t    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] rst_cnt;
  logic          we_q;
  logic          sh_wr;

  // cart_nrst rises on the RST_CYC-th edge after reset is released
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cart_nrst <= 1'b0;
      rst_cnt   <= '0;
    end else if (!cart_nrst) begin
      if (rst_cnt == CW'(RST_CYC - 1)) cart_nrst <= 1'b1;
      else                             rst_cnt   <= rst_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      cart_a     <= 16'd0;
      cart_d_out <= 8'd0;
      cart_d_oe  <= 1'b0;
      cart_nrd   <= 1'b1;
      cart_nwr   <= 1'b1;
      cart_ncs   <= 1'b1;
      ack        <= 1'b0;
      rdata      <= 8'd0;
    end else begin
      ack <= 1'b0;
      case (state)
        IDLE: begin
          if (req && cart_nrst) begin
            we_q      <= we;
            cart_a    <= addr;
            cart_d_oe <= we;
            cart_ncs  <= !in_ram_window(addr);
            if (we) cart_d_out <= wdata;
            cnt       <= CW'(SETUP_CYC - 1);
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            cart_nrd <= we_q;
            cart_nwr <= !we_q;
            cnt      <= CW'(STROBE_CYC - 1);
            state    <= STROBE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STROBE: begin
          if (cnt == '0) begin
            cart_nrd <= 1'b1;
            cart_nwr <= 1'b1;
            if (!we_q) rdata <= cart_d_in;
            cnt      <= CW'(HOLD_CYC - 1);
            state    <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            ack       <= 1'b1;
            cart_d_oe <= 1'b0;
            cart_ncs  <= 1'b1;
            state     <= ACK;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy  = (state != IDLE) || !cart_nrst;
  assign sh_wr = (state == STROBE) && (cnt == '0) && we_q;

  mbc1_shadow u_shadow (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (sh_wr),
    .addr_hi  (cart_a[15:13]),
    .data     (cart_d_out[4:0]),
    .ram_ena  (sh_ram_ena),
    .rom_bank (sh_rom_bank),
    .ram_bank (sh_ram_bank),
    .mode     (sh_mode)
  );

endmodule

// File: tb/tb_cart_bus_seq.sv
// Scoreboard bench for cart_bus_seq: directed requests push expected read data and shadow
// state, and a negedge monitor pops and compares on every ack.
module tb_cart_bus_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [15:0] addr = 16'd0;
  logic [7:0]  wdata = 8'd0;
  logic [7:0]  cart_d_in = 8'hEE;
  logic        ack, busy, cart_nrst, cart_d_oe, cart_nrd, cart_nwr, cart_ncs;
  logic [7:0]  rdata, cart_d_out;
  logic [15:0] cart_a;
  logic        sh_ram_ena, sh_mode;
  logic [4:0]  sh_rom_bank;
  logic [1:0]  sh_ram_bank;

  always #5 clk = ~clk;

  cart_bus_seq dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .we          (we),
    .addr        (addr),
    .wdata       (wdata),
    .ack         (ack),
    .rdata       (rdata),
    .busy        (busy),
    .cart_nrst   (cart_nrst),
    .cart_a      (cart_a),
    .cart_d_out  (cart_d_out),
    .cart_d_oe   (cart_d_oe),
    .cart_d_in   (cart_d_in),
    .cart_nrd    (cart_nrd),
    .cart_nwr    (cart_nwr),
    .cart_ncs    (cart_ncs),
    .sh_ram_ena  (sh_ram_ena),
    .sh_rom_bank (sh_rom_bank),
    .sh_ram_bank (sh_ram_bank),
    .sh_mode     (sh_mode)
  );

  typedef struct {
    logic [7:0] rd;
    logic [4:0] rom;
    logic       ena;
    logic [1:0] rbank;
    logic       mode;
  } exp_t;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic [7:0]  din;
    logic        ncs_low;
    exp_t        e;
  } vec_t;

  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;
  int overlap = 0;

  task automatic checkOutput(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkVec(input logic w, input logic [15:0] a, input logic [7:0] wd,
                                 input logic [7:0] din, input logic ncs_low, input logic [7:0] rd,
                                 input logic [4:0] rom, input logic ena, input logic [1:0] rbank,
                                 input logic mode);
    vec_t v;
    v.we = w; v.addr = a; v.wd = wd; v.din = din; v.ncs_low = ncs_low;
    v.e.rd = rd; v.e.rom = rom; v.e.ena = ena; v.e.rbank = rbank; v.e.mode = mode;
    return v;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!cart_nrd && !cart_nwr) overlap++;
    if (ack) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_ack", int'(ack), 0);
      end else begin
        e = sb.pop_front();
        checkOutput("rdata", int'(rdata), int'(e.rd));
        checkOutput("sh_rom_bank", int'(sh_rom_bank), int'(e.rom));
        checkOutput("sh_ram_ena", int'(sh_ram_ena), int'(e.ena));
        checkOutput("sh_ram_bank", int'(sh_ram_bank), int'(e.rbank));
        checkOutput("sh_mode", int'(sh_mode), int'(e.mode));
      end
    end
  end

  // Issues one request and counts per-cycle bus activity over the 7 cycles after accept
  task automatic applyStimulus(input vec_t v, input bit hold_req, output int acc_cyc);
    int n = 0;
    int nrd_lo = 0, nwr_lo = 0, oe_hi = 0, ncs_lo = 0, ack_k = 0;
    we = v.we; addr = v.addr; wdata = v.wd; req = 1'b1;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_wait", int'(busy), 0);
    sb.push_back(v.e);
    @(posedge clk);
    acc_cyc = int'($time / 10);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (!hold_req) req = 1'b0;
        checkOutput("accepted", int'(busy), 1);
        checkOutput("cart_a_setup", int'(cart_a), int'(v.addr));
      end
      cart_d_in = (k == 5) ? v.din : 8'hEE;
      if (!cart_nrd) nrd_lo++;
      if (!cart_nwr) nwr_lo++;
      if (cart_d_oe) oe_hi++;
      if (!cart_ncs) ncs_lo++;
      if (ack && ack_k == 0) ack_k = k;
      if (k == 6) begin
        checkOutput("cart_a_hold", int'(cart_a), int'(v.addr));
        if (v.we) checkOutput("d_out_hold", int'(cart_d_out), int'(v.wd));
      end
    end
    checkOutput("nrd_low_cycles", nrd_lo, v.we ? 0 : 3);
    checkOutput("nwr_low_cycles", nwr_lo, v.we ? 3 : 0);
    checkOutput("d_oe_cycles", oe_hi, v.we ? 6 : 0);
    checkOutput("ncs_low_cycles", ncs_lo, v.ncs_low ? 6 : 0);
    checkOutput("ack_cycle", ack_k, 7);
  endtask

  // Called at the negedge where reset was released
  task automatic countReset();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!cart_nrst && k < 20);
    checkOutput("nrst_low_edges", k, 8);
    checkOutput("idle_after_nrst", int'(busy), 0);
    req = 1'b0;
  endtask

  initial begin
    vec_t v[15];
    int t0, t1, n;

    v[0]  = mkVec(1'b0, 16'h4000, 8'h00, 8'h5A, 1'b0, 8'h5A, 5'h00, 1'b0, 2'd0, 1'b0);
    v[1]  = mkVec(1'b1, 16'h2000, 8'h00, 8'h00, 1'b0, 8'h5A, 5'h00, 1'b0, 2'd0, 1'b0);
    v[2]  = mkVec(1'b1, 16'h2000, 8'h13, 8'h00, 1'b0, 8'h5A, 5'h13, 1'b0, 2'd0, 1'b0);
    v[3]  = mkVec(1'b1, 16'h0000, 8'h0A, 8'h00, 1'b0, 8'h5A, 5'h13, 1'b1, 2'd0, 1'b0);
    v[4]  = mkVec(1'b1, 16'hA123, 8'h77, 8'h00, 1'b1, 8'h5A, 5'h13, 1'b1, 2'd0, 1'b0);
    v[5]  = mkVec(1'b0, 16'hFE00, 8'h00, 8'h3C, 1'b0, 8'h3C, 5'h13, 1'b1, 2'd0, 1'b0);
    v[6]  = mkVec(1'b1, 16'h4000, 8'h02, 8'h00, 1'b0, 8'h3C, 5'h13, 1'b1, 2'd2, 1'b0);
    v[7]  = mkVec(1'b1, 16'h6000, 8'h01, 8'h00, 1'b0, 8'h3C, 5'h13, 1'b1, 2'd2, 1'b1);
    v[8]  = mkVec(1'b1, 16'h0000, 8'h0B, 8'h00, 1'b0, 8'h3C, 5'h13, 1'b0, 2'd2, 1'b1);
    v[9]  = mkVec(1'b0, 16'hA000, 8'h00, 8'hC3, 1'b1, 8'hC3, 5'h13, 1'b0, 2'd2, 1'b1);
    v[10] = mkVec(1'b0, 16'hFDFF, 8'h00, 8'h81, 1'b1, 8'h81, 5'h13, 1'b0, 2'd2, 1'b1);
    v[11] = mkVec(1'b1, 16'h8000, 8'h1F, 8'h00, 1'b0, 8'h81, 5'h13, 1'b0, 2'd2, 1'b1);
    v[12] = mkVec(1'b0, 16'h1234, 8'h00, 8'h11, 1'b0, 8'h11, 5'h13, 1'b0, 2'd2, 1'b1);
    v[13] = mkVec(1'b0, 16'h5678, 8'h00, 8'h22, 1'b0, 8'h22, 5'h13, 1'b0, 2'd2, 1'b1);
    v[14] = mkVec(1'b0, 16'h0000, 8'h00, 8'h99, 1'b0, 8'h99, 5'h00, 1'b0, 2'd0, 1'b0);

    // Power-up with req held high through the cartridge-reset window
    reset = 1'b1; req = 1'b1; we = 1'b0; addr = 16'h4000;
    repeat (3) @(negedge clk);
    checkOutput("reset_ctrl", int'({cart_nrst, cart_nrd, cart_nwr, cart_ncs, cart_d_oe, ack, busy}),
                int'(7'b0111001));
    checkOutput("reset_bus", int'({cart_a, cart_d_out, rdata}), 0);
    checkOutput("reset_shadow", int'({sh_ram_ena, sh_rom_bank, sh_ram_bank, sh_mode}), 0);
    reset = 1'b0;
    countReset();

    for (int i = 0; i < 12; i++) applyStimulus(v[i], 1'b0, t0);

    $display("[TB] back-to-back reads");
    applyStimulus(v[12], 1'b1, t0);
    applyStimulus(v[13], 1'b0, t1);
    checkOutput("b2b_spacing", t1 - t0, 8);

    $display("[TB] reset during write strobe");
    we = 1'b1; addr = 16'h6000; wdata = 8'h01; req = 1'b1;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    n = 0;
    while (cart_nwr && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput("nwr_reached", int'(cart_nwr), 0);
    reset = 1'b1;
    #1;
    checkOutput("abort_bus", int'({cart_nwr, cart_nrd, cart_ncs, cart_d_oe, ack, cart_nrst}),
                int'(6'b111000));
    checkOutput("abort_shadow", int'({sh_ram_ena, sh_rom_bank, sh_ram_bank, sh_mode}), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    countReset();

    applyStimulus(v[14], 1'b0, t0);
    @(negedge clk);
    checkOutput("sb_empty", sb.size(), 0);
    checkOutput("strobe_overlap", overlap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
